// File: rtl/tx_sequencer.sv
// ISO/IEC 14443-2 Type A PICC transmit sequencer: SOC, Manchester data bits, EOC.
// Optional odd-parity insertion after every 8 data bits when TX_SEQUENCER_PARITY_EN is defined.
module tx_sequencer #(
  parameter int BIT_PERIOD = 128,
  parameter int EOC_PERIOD = 128
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_data,
  input  logic in_last,
  output logic in_ready,
  input  logic subcarrier,
  output logic sc_en,
  output logic tx_mod,
  output logic busy,
  output logic done,
  output logic underflow
);

  localparam int MAX_PERIOD = (BIT_PERIOD > EOC_PERIOD) ? BIT_PERIOD : EOC_PERIOD;
  localparam int CW = $clog2(MAX_PERIOD);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(BIT_PERIOD / 2);
  localparam logic [CW-1:0] EOC_LAST = CW'(EOC_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, SOC, DATA, EOC} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          cur_bit_q, cur_bit_d;
  logic          cur_last_q, cur_last_d;
  logic          mod_gate_q, mod_gate_d;
  logic          sc_en_q, sc_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          underflow_q, underflow_d;
  logic          half;
  logic          eff_bit;
  logic          active;

`ifdef TX_SEQUENCER_PARITY_EN
  logic [2:0] byte_cnt_q, byte_cnt_d;
  logic       par_q, par_d;
  logic       par_pend_q, par_pend_d;
  logic       par_last_q, par_last_d;
`endif

  assign half    = (bit_cnt_q >= BIT_HALF);
  assign eff_bit = (state_q == SOC) ? 1'b1 : cur_bit_q;
  assign active  = eff_bit ? !half : half;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cur_bit_d   = cur_bit_q;
    cur_last_d  = cur_last_q;
    mod_gate_d  = 1'b0;
    sc_en_d     = sc_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    underflow_d = 1'b0;
    in_ready    = 1'b0;
`ifdef TX_SEQUENCER_PARITY_EN
    byte_cnt_d  = byte_cnt_q;
    par_d       = par_q;
    par_pend_d  = par_pend_q;
    par_last_d  = par_last_q;
`endif
    case (state_q)
      IDLE: begin
        // The triggering bit is not consumed here; SOC is sent first.
        if (in_valid) begin
          state_d    = SOC;
          bit_cnt_d  = '0;
          sc_en_d    = 1'b1;
          busy_d     = 1'b1;
          cur_bit_d  = 1'b0;
          cur_last_d = 1'b0;
`ifdef TX_SEQUENCER_PARITY_EN
          byte_cnt_d = 3'd0;
          par_d      = 1'b0;
          par_pend_d = 1'b0;
          par_last_d = 1'b0;
`endif
        end
      end
      SOC, DATA: begin
        mod_gate_d = active;
        bit_cnt_d  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + CNT_ONE;
        if (bit_cnt_q == BIT_LAST) begin
          if (cur_last_q) begin
            state_d = EOC;
            sc_en_d = 1'b0;
          end
`ifdef TX_SEQUENCER_PARITY_EN
          else if (par_pend_q) begin
            state_d    = DATA;
            cur_bit_d  = ~par_q;
            cur_last_d = par_last_q;
            par_pend_d = 1'b0;
            par_d      = 1'b0;
          end
`endif
          else begin
            in_ready = 1'b1;
            if (in_valid) begin
              state_d    = DATA;
              cur_bit_d  = in_data;
              cur_last_d = in_last;
`ifdef TX_SEQUENCER_PARITY_EN
              byte_cnt_d = byte_cnt_q + 3'd1;
              par_d      = par_q ^ in_data;
              // 8th bit of a byte: defer the last flag onto the parity bit.
              if (byte_cnt_q == 3'd7) begin
                par_pend_d = 1'b1;
                par_last_d = in_last;
                cur_last_d = 1'b0;
              end
`endif
            end else begin
              underflow_d = 1'b1;
              state_d     = EOC;
              sc_en_d     = 1'b0;
            end
          end
        end
      end
      EOC: begin
        if (bit_cnt_q == EOC_LAST) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sc_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cur_bit_q   <= 1'b0;
      cur_last_q  <= 1'b0;
      mod_gate_q  <= 1'b0;
      sc_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cur_bit_q   <= cur_bit_d;
      cur_last_q  <= cur_last_d;
      mod_gate_q  <= mod_gate_d;
      sc_en_q     <= sc_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef TX_SEQUENCER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= 3'd0;
      par_q      <= 1'b0;
      par_pend_q <= 1'b0;
      par_last_q <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      par_q      <= par_d;
      par_pend_q <= par_pend_d;
      par_last_q <= par_last_d;
    end
  end
`endif

  // mod_gate lags one tick, matching the generator's lag behind sc_en.
  assign tx_mod    = subcarrier && mod_gate_q;
  assign sc_en     = sc_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_tx_sequencer.sv
// Self-checking bench for tx_sequencer: vector table, random frames against a
// timeline model, reset corner cases.
module tb_tx_sequencer;

  localparam int BP = 128;
  localparam int EP = 128;
`ifdef TX_SEQUENCER_PARITY_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_data = 1'b0;
  logic in_last = 1'b0;
  logic subcarrier = 1'b0;
  logic in_ready, sc_en, tx_mod, busy, done, underflow;

  int total = 0;
  int bad = 0;
  int cur_n = 0;
  logic [3:0] sc_cnt = 4'd0;
  bit q_data[$];
  bit q_last[$];

  always #5 clk = ~clk;

  tx_sequencer #(.BIT_PERIOD(BP), .EOC_PERIOD(EP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .subcarrier(subcarrier),
    .sc_en(sc_en), .tx_mod(tx_mod), .busy(busy), .done(done),
    .underflow(underflow)
  );

  // Subcarrier generator: high 1 tick after en, toggles every 8 ticks.
  always @(posedge clk) begin
    if (!sc_en) begin
      sc_cnt     <= 4'd0;
      subcarrier <= 1'b0;
    end else begin
      sc_cnt     <= sc_cnt + 4'd1;
      subcarrier <= ~sc_cnt[3];
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s n=%0d actual=%b required=%b", name, cur_n, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive_head(input bit noise);
    if (q_data.size() > 0) begin
      in_valid = 1'b1;
      in_data  = q_data[0];
      in_last  = q_last[0];
    end else begin
      in_valid = noise;
      in_data  = 1'($urandom);
      in_last  = 1'($urandom);
    end
  endtask

  // Expected behaviour derived from the frame contents: bit b occupies edges
  // 128*b+1 .. 128*b+128 after E0, followed by EOC and a done pulse.
  task automatic run_frame(input logic [31:0] d, input int len, input bit has_last,
                           input bit noise, input int exp_nbits, input int exp_rdy,
                           input int id);
    bit txb[$];
    bit rf[$];
    bit par;
    bit uf;
    int nb;
    int endn;
    int rdy_cnt;
    int done_at;
    txb.push_back(1'b1);
    rf.push_back(1'b0);
    par = 1'b0;
    for (int i = 0; i < len; i++) begin
      q_data.push_back(d[i]);
      q_last.push_back(has_last && (i == len - 1));
      txb.push_back(d[i]);
      rf.push_back(1'b1);
      par ^= d[i];
      if (PX == 1 && (i % 8) == 7) begin
        txb.push_back(~par);
        rf.push_back(1'b0);
        par = 1'b0;
      end
    end
    nb = txb.size();
    uf = !has_last;
    endn = BP * nb + EP;
    rdy_cnt = 0;
    done_at = -1;
    @(negedge clk);
    drive_head(1'b0);
    @(posedge clk);
    for (int n = 0; n <= endn + 3; n++) begin
      bit g;
      bit e_rdy;
      bit cons;
      int k;
      @(negedge clk);
      cur_n = n;
      g = 1'b0;
      if (n >= 1 && n <= BP * nb)
        g = txb[(n - 1) / BP] ? (((n - 1) % BP) < BP / 2) : (((n - 1) % BP) >= BP / 2);
      k = (n + 1) / BP;
      e_rdy = ((n + 1) % BP == 0) && (k >= 1) && ((k < nb && rf[k]) || (k == nb && uf));
      chk("sc_en", sc_en, n < BP * nb);
      chk("busy", busy, n < endn);
      chk("done", done, n == endn);
      chk("underflow", underflow, uf && n == BP * nb);
      chk("in_ready", in_ready, e_rdy);
      chk("tx_mod", tx_mod, g && subcarrier);
      if (in_ready) rdy_cnt++;
      if (done) done_at = n;
      cons = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (cons && q_data.size() > 0) begin
        void'(q_data.pop_front());
        void'(q_last.pop_front());
      end
      drive_head(noise && q_data.size() == 0 && n > BP * nb && n < endn - 8);
    end
    if (exp_nbits > 0) begin
      chk_int("done_edge", done_at, BP * exp_nbits + EP);
      chk_int("ready_pulses", rdy_cnt, exp_rdy);
    end
    $display("frame %0d: len=%0d last=%0b bits_on_air=%0d ready=%0d done_at=%0d", id, len,
             has_last, nb, rdy_cnt, done_at);
    q_data.delete();
    q_last.delete();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  typedef struct {
    logic [31:0] d;
    int          len;
    bit          has_last;
    bit          noise;
    int          nbits;
    int          rdy;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{32'h0000_0000, 1, 1'b1, 1'b0, 2, 1};
    tbl[1] = '{32'h0000_000D, 4, 1'b1, 1'b0, 5, 4};
    tbl[2] = '{32'h0000_0001, 1, 1'b0, 1'b0, 2, 2};
    tbl[3] = '{32'h0000_00A5, 8, 1'b1, 1'b1, 9 + PX, 8};
    tbl[4] = '{32'h0000_0000, 8, 1'b1, 1'b0, 9 + PX, 8};
    tbl[5] = '{32'h0000_0003, 3, 1'b1, 1'b0, 4, 3};
    tbl[6] = '{32'h0000_00C3, 8, 1'b0, 1'b0, 9 + PX, 9};

    // Reset state, then a long idle with no upstream data.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sc_en", sc_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    chk("rst_tx_mod", tx_mod, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      cur_n = i;
      chk("idle_sc_en", sc_en, 1'b0);
      chk("idle_tx_mod", tx_mod, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_in_ready", in_ready, 1'b0);
    end
    $display("idle: 500 cycles checked");

    for (int i = 0; i < 7; i++)
      run_frame(tbl[i].d, tbl[i].len, tbl[i].has_last, tbl[i].noise, tbl[i].nbits,
                tbl[i].rdy, i);

    // Asynchronous reset while a data bit is on air (bit_cnt=40).
    q_data.push_back(1'b1);
    q_last.push_back(1'b0);
    @(negedge clk);
    drive_head(1'b0);
    @(posedge clk);
    repeat (BP + 40) @(posedge clk);
    #1;
    cur_n = BP + 40;
    chk("mid_busy_pre", busy, 1'b1);
    chk("mid_sc_en_pre", sc_en, 1'b1);
    chk("mid_tx_mod_pre", tx_mod, subcarrier);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_sc_en", sc_en, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_tx_mod", tx_mod, 1'b0);
    chk("mid_in_ready", in_ready, 1'b0);
    q_data.delete();
    q_last.delete();
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    $display("mid-frame reset applied");
    run_frame(32'h0000_0006, 4, 1'b1, 1'b0, 5, 4, 100);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] rd;
      int rl;
      bit rlast;
      bit rnoise;
      rd     = $urandom;
      rl     = $urandom_range(1, 16);
      rlast  = ($urandom_range(0, 3) != 0);
      rnoise = 1'($urandom);
      run_frame(rd, rl, rlast, rnoise, 0, 0, 200 + i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
